// File: rtl/bsg_mem_1rw_rv_pkg.sv
// Shared types for the valid/ready 1RW bit-masked RAM front end.
// Holds the controller state encoding and an address-width helper.
package bsg_mem_1rw_rv_pkg;

   typedef enum logic {
      eCLEAR = 1'b0,
      eRUN   = 1'b1
   } state_e;

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_rv_two_fifo.sv
// Two-entry response buffer with valid/ready enqueue and
// valid/yumi dequeue; holds read data the RAM shows for one cycle.
module bsg_two_fifo #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   output logic               ready_o,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_q [2];
   logic               rptr_q, wptr_q;
   logic [1:0]         cnt_q, cnt_d;
   logic               enq, deq;

   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;
   assign v_o     = (cnt_q != 2'd0);
   assign ready_o = (cnt_q != 2'd2);
   assign data_o  = mem_q[rptr_q];
   assign cnt_d   = cnt_q + {1'b0, enq} - {1'b0, deq};

   // pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rptr_q <= 1'b0;
         wptr_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         rptr_q <= rptr_q ^ deq;
         wptr_q <= wptr_q ^ enq;
         cnt_q  <= cnt_d;
      end
   end

   // storage, written on enqueue only
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_rv.sv
// Valid/ready front end for a synchronous 1RW bit-masked RAM.
// Optional post-reset zero fill: BSG_MEM_1RW_SYNC_MASK_WRITE_BIT_RV_CLEAR_EN.
module bsg_mem_1rw_sync_mask_write_bit_rv
   import bsg_mem_1rw_rv_pkg::*;
#(
   parameter int width_p       = 8,
   parameter int els_p         = 16,
   parameter int addr_width_lp = safe_clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [width_p-1:0]       data_i,
   input  logic [width_p-1:0]       w_mask_i,
   output logic                     ready_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   input  logic                     yumi_i,
   output logic                     mem_v_o,
   output logic                     mem_w_o,
   output logic [addr_width_lp-1:0] mem_addr_o,
   output logic [width_p-1:0]       mem_data_o,
   output logic [width_p-1:0]       mem_w_mask_o,
   input  logic [width_p-1:0]       mem_data_i
);

   state_e             state_q, state_d;
   logic               inflight_q, inflight_d;
   logic               fifo_v, fifo_ready, fifo_enq, fifo_deq;
   logic [width_p-1:0] fifo_data;
   logic [1:0]         fifo_count, pending;
   logic               run, accept;

`ifdef BSG_MEM_1RW_SYNC_MASK_WRITE_BIT_RV_CLEAR_EN
   localparam state_e reset_state_lp = eCLEAR;
   localparam logic [addr_width_lp:0] last_lp =
      (addr_width_lp + 1)'(els_p - 1);

   // one extra bit so a power-of-two depth cannot wrap early
   logic [addr_width_lp:0] cnt_q, cnt_d;
   logic                   clear_v;

   assign clear_v = ~reset_i & (state_q == eCLEAR);
   assign cnt_d   = clear_v
                  ? cnt_q + {{addr_width_lp{1'b0}}, 1'b1}
                  : cnt_q;

   // zero-fill address counter
   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign mem_v_o      = accept | clear_v;
   assign mem_w_o      = clear_v | w_i;
   assign mem_addr_o   = clear_v ? cnt_q[addr_width_lp-1:0] : addr_i;
   assign mem_data_o   = clear_v ? '0 : data_i;
   assign mem_w_mask_o = clear_v ? '1 : w_mask_i;
`else
   localparam state_e reset_state_lp = eRUN;

   assign mem_v_o      = accept;
   assign mem_w_o      = w_i;
   assign mem_addr_o   = addr_i;
   assign mem_data_o   = data_i;
   assign mem_w_mask_o = w_mask_i;
`endif

   // next state: leave clear once the last word is written
   always_comb begin
      state_d = state_q;
`ifdef BSG_MEM_1RW_SYNC_MASK_WRITE_BIT_RV_CLEAR_EN
      if (clear_v && (cnt_q == last_lp)) state_d = eRUN;
`endif
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= reset_state_lp;
      else         state_q <= state_d;
   end

   assign fifo_count = fifo_ready ? {1'b0, fifo_v} : 2'd2;
   assign pending    = fifo_count + {1'b0, inflight_q};
   assign run        = ~reset_i & (state_q == eRUN);
   assign ready_o    = run & (pending < 2'd2);
   assign accept     = v_i & ready_o;
   assign inflight_d = accept & ~w_i;

   // read issued last cycle: RAM data shows up this cycle
   always_ff @(posedge clk_i) begin
      if (reset_i) inflight_q <= 1'b0;
      else         inflight_q <= inflight_d;
   end

   // bypass when empty, otherwise keep order through the buffer
   assign v_o      = ~reset_i & (fifo_v | inflight_q);
   assign data_o   = fifo_v ? fifo_data : mem_data_i;
   assign fifo_enq = ~reset_i & inflight_q & (fifo_v | ~yumi_i);
   assign fifo_deq = ~reset_i & yumi_i & fifo_v;

   bsg_two_fifo #(
      .width_p(width_p)
   ) resp_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .ready_o(fifo_ready),
      .v_i    (fifo_enq),
      .data_i (mem_data_i),
      .v_o    (fifo_v),
      .data_o (fifo_data),
      .yumi_i (fifo_deq)
   );

   yumi_needs_v: assert property (
      @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
   );

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_rv.sv
// Directed and scoreboarded bench for the 1RW RAM valid/ready front end.
// Contains a behavioural model of the attached synchronous RAM.
module tb_bsg_mem_1rw_sync_mask_write_bit_rv;

   localparam int W = 8;
   localparam int E = 16;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         reset_i;
   logic         v_i, w_i, yumi_i;
   logic [A-1:0] addr_i;
   logic [W-1:0] data_i, w_mask_i;
   logic         ready_o, v_o;
   logic [W-1:0] data_o;
   logic         mem_v_o, mem_w_o;
   logic [A-1:0] mem_addr_o;
   logic [W-1:0] mem_data_o, mem_w_mask_o, mem_data_i;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] ram [E];
   logic [W-1:0] shadow [E];
   logic [W-1:0] q [$];

   always #5 clk = ~clk;

   bsg_mem_1rw_sync_mask_write_bit_rv #(
      .width_p(W),
      .els_p  (E)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .v_i         (v_i),
      .w_i         (w_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .w_mask_i    (w_mask_i),
      .ready_o     (ready_o),
      .v_o         (v_o),
      .data_o      (data_o),
      .yumi_i      (yumi_i),
      .mem_v_o     (mem_v_o),
      .mem_w_o     (mem_w_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_w_mask_o(mem_w_mask_o),
      .mem_data_i  (mem_data_i)
   );

   // synchronous RAM: read data valid for exactly one cycle
   always @(posedge clk) begin
      if (mem_v_o && mem_w_o)
         ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_w_mask_o)
                          | (mem_data_o & mem_w_mask_o);
      if (mem_v_o && !mem_w_o) mem_data_i <= ram[mem_addr_o];
      else                     mem_data_i <= 'x;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic w,
                        input logic [A-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] m, input logic y);
      v_i = v; w_i = w; addr_i = a;
      data_i = d; w_mask_i = m; yumi_i = y;
   endtask

   task automatic rd(input logic [A-1:0] a, input logic y);
      drive(1'b1, 1'b0, a, 8'h00, 8'h00, y);
   endtask

   task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d,
                     input logic [W-1:0] m);
      drive(1'b1, 1'b1, a, d, m, 1'b0);
   endtask

   task automatic idle(input logic y);
      drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, y);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!ready_o && k < 40) begin
         cyc();
         k++;
      end
      chk("ready_after_clear", ready_o, 1'b1);
   endtask

   initial begin
      logic         v, w, y, er;
      logic [A-1:0] a;
      logic [W-1:0] d, m;

      reset_i = 1'b1;
      rd(4'd7, 1'b0);
      cyc();
      #4;
      chk("reset_ready", ready_o, 1'b0);
      chk("reset_v_o", v_o, 1'b0);
      chk("reset_mem_v", mem_v_o, 1'b0);
      cyc();
      reset_i = 1'b0;
      idle(1'b0);

`ifdef BSG_MEM_1RW_SYNC_MASK_WRITE_BIT_RV_CLEAR_EN
      for (int i = 0; i < E; i++) begin
         #4;
         chk("clr_mem_v", mem_v_o, 1'b1);
         chk("clr_mem_w", mem_w_o, 1'b1);
         chk("clr_addr", mem_addr_o, i);
         chk("clr_data", mem_data_o, 8'h00);
         chk("clr_mask", mem_w_mask_o, 8'hFF);
         chk("clr_ready", ready_o, 1'b0);
         cyc();
      end
      #4;
      chk("clr_ready_17", ready_o, 1'b1);
      cyc();
      rd(4'd5, 1'b0);
      cyc();
      idle(1'b1);
      #4;
      chk("clr_rd5_v", v_o, 1'b1);
      chk("clr_rd5_data", data_o, 8'h00);
      cyc();
      idle(1'b0);
`else
      #4;
      chk("first_ready", ready_o, 1'b1);
      cyc();
`endif

      wr(4'd3, 8'hFF, 8'hFF);
      #4;
      chk("wr_mem_v", mem_v_o, 1'b1);
      chk("wr_mem_w", mem_w_o, 1'b1);
      chk("wr_mem_addr", mem_addr_o, 4'd3);
      cyc();
      wr(4'd3, 8'hA5, 8'h0F);
      #4;
      chk("wr_no_resp", v_o, 1'b0);
      cyc();
      rd(4'd3, 1'b0);
      #4;
      chk("rd_t_v", v_o, 1'b0);
      cyc();
      idle(1'b1);
      #4;
      chk("mask_v", v_o, 1'b1);
      chk("mask_data", data_o, 8'hF5);
      cyc();
      wr(4'd1, 8'h11, 8'hFF);
      #4;
      chk("after_v", v_o, 1'b0);
      cyc();
      wr(4'd2, 8'h22, 8'hFF);
      cyc();

      rd(4'd1, 1'b0);
      #4;
      chk("b2b_ready1", ready_o, 1'b1);
      cyc();
      rd(4'd2, 1'b1);
      #4;
      chk("b2b_ready2", ready_o, 1'b1);
      chk("b2b_v1", v_o, 1'b1);
      chk("b2b_d1", data_o, 8'h11);
      cyc();
      rd(4'd3, 1'b1);
      #4;
      chk("b2b_ready3", ready_o, 1'b1);
      chk("b2b_v2", v_o, 1'b1);
      chk("b2b_d2", data_o, 8'h22);
      cyc();
      idle(1'b1);
      #4;
      chk("b2b_v3", v_o, 1'b1);
      chk("b2b_d3", data_o, 8'hF5);
      cyc();
      idle(1'b0);
      #4;
      chk("b2b_drained", v_o, 1'b0);
      cyc();

      rd(4'd1, 1'b0);
      cyc();
      rd(4'd2, 1'b0);
      #4;
      chk("bp_ready_1", ready_o, 1'b1);
      chk("bp_bypass_v", v_o, 1'b1);
      chk("bp_bypass_d", data_o, 8'h11);
      cyc();
      rd(4'd3, 1'b0);
      #4;
      chk("bp_ready_low", ready_o, 1'b0);
      chk("bp_mem_v_low", mem_v_o, 1'b0);
      chk("bp_hold_d", data_o, 8'h11);
      cyc();
      rd(4'd3, 1'b1);
      #4;
      chk("bp_ready_still", ready_o, 1'b0);
      chk("bp_pop1_v", v_o, 1'b1);
      chk("bp_pop1_d", data_o, 8'h11);
      cyc();
      idle(1'b1);
      #4;
      chk("bp_ready_back", ready_o, 1'b1);
      chk("bp_pop2_v", v_o, 1'b1);
      chk("bp_pop2_d", data_o, 8'h22);
      cyc();
      idle(1'b0);
      #4;
      chk("bp_empty", v_o, 1'b0);
      cyc();

      rd(4'd1, 1'b0);
      cyc();
      rd(4'd2, 1'b0);
      cyc();
      reset_i = 1'b1;
      idle(1'b0);
      #4;
      chk("mid_rst_v", v_o, 1'b0);
      chk("mid_rst_ready", ready_o, 1'b0);
      cyc();
      reset_i = 1'b0;
      #4;
      chk("post_rst_v", v_o, 1'b0);
`ifdef BSG_MEM_1RW_SYNC_MASK_WRITE_BIT_RV_CLEAR_EN
      cyc();
      wait_ready();
`else
      chk("post_rst_ready", ready_o, 1'b1);
      cyc();
`endif
      #4;
      chk("post_rst_stale", v_o, 1'b0);
      cyc();

      for (int i = 0; i < E; i++) begin
         d = 8'($urandom);
         wr(4'(i), d, 8'hFF);
         shadow[i] = d;
         cyc();
      end
      idle(1'b0);

      for (int c = 0; c < 10000; c++) begin
         er = (q.size() < 2);
         chk("rnd_v_o", v_o, q.size() > 0);
         chk("rnd_ready", ready_o, er);
         v = ($urandom_range(0, 3) != 0);
         w = ($urandom_range(0, 2) == 0);
         a = 4'($urandom);
         d = 8'($urandom);
         m = 8'($urandom);
         y = (q.size() > 0) && ($urandom_range(0, 3) != 0);
         drive(v, w, a, d, m, y);
         #4;
         if (y) begin
            chk("rnd_data", data_o, q[0]);
            void'(q.pop_front());
         end
         if (v && er) begin
            if (w) shadow[a] = (shadow[a] & ~m) | (d & m);
            else   q.push_back(shadow[a]);
         end
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_bit_rv.md
# bsg_mem_1rw_sync_mask_write_bit_rv

Valid/ready front end for a synchronous 1RW bit-masked RAM (`bsg_mem_1rw_sync_mask_write_bit`). It accepts read/write requests over a ready-valid handshake and issues one RAM operation per cycle. It captures read data, which the RAM presents for exactly one cycle, into a 2-entry response buffer with a bypass path, so the consumer can apply backpressure via `yumi_i`. It optionally zero-fills the RAM after reset.

## Interface
Parameters:
- `width_p`, no default, data and mask width in bits.
- `els_p`, no default, number of RAM words.
- `addr_width_lp`, `BSG_SAFE_CLOG2(els_p)`, address width (derived).

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `v_i`  in  1  request valid.
- `w_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  addr_width_lp  request address.
- `data_i`  in  width_p  write data.
- `w_mask_i`  in  width_p  per-bit write enable.
- `ready_o`  out  1  request accepted when `v_i & ready_o`.
- `v_o`  out  1  read response valid.
- `data_o`  out  width_p  read response data.
- `yumi_i`  in  1  consumer takes the response; legal only when `v_o`.
- `mem_v_o`, `mem_w_o`  out  1  RAM port valid and write.
- `mem_addr_o`  out  addr_width_lp  RAM address.
- `mem_data_o`, `mem_w_mask_o`  out  width_p  RAM write data and mask.
- `mem_data_i`  in  width_p  RAM read data, valid the cycle after the read.

## Operation
- FSM states: `eCLEAR` (only with the macro), `eRUN`.
- Reset enters `eCLEAR` if the macro is defined, otherwise `eRUN`.
- Request pass-through: `mem_v_o = v_i & ready_o`. `mem_w_o`, `mem_addr_o`, `mem_data_o` and `mem_w_mask_o` follow the request combinationally.
- `inflight_r` is set when a read is accepted and cleared the next cycle.
- `pending = fifo_count + inflight_r`, range 0..2.
- `ready_o = (state == eRUN) & (pending < 2)`. It does not depend on `v_i`, `w_i` or `yumi_i`.
  - Writes are gated the same way as reads, for simplicity.
- Response path, in the cycle where `inflight_r = 1`:
  - FIFO empty: bypass. `v_o = 1`, `data_o = mem_data_i`.
  - If `yumi_i` is low in that cycle, `mem_data_i` is enqueued.
  - FIFO non-empty: `mem_data_i` is enqueued behind the existing entries and `data_o` is the FIFO head.
- FIFO never overflows, guaranteed by the `pending < 2` rule.
- Responses return in request order.
- Writes produce no response.
- `yumi_i` without `v_o` is illegal and is asserted against in simulation.

## Timing
- Reset values: `ready_o = 0` during reset; `v_o = 0`; `mem_v_o = 0`; FIFO empty; `inflight_r = 0`.
- Reset mid-operation discards in-flight and buffered reads and restarts the FSM.
- Read latency: accepted in cycle t, `v_o` in cycle t+1 (bypass).
- Throughput: one read per cycle while `yumi_i` is held high.
- Write: RAM is updated at the clock edge ending cycle t; a read accepted at t+1 returns the new data.
- Backpressure: at most 2 responses outstanding.
  - Two reads accepted with `yumi_i = 0` makes `ready_o = 0` from the next cycle.
  - `ready_o` rises the cycle after a `yumi_i`.

## Configuration
Macro `BSG_MEM_1RW_SYNC_MASK_WRITE_BIT_RV_CLEAR_EN`.

- Defined:
  - After reset deasserts, `eCLEAR` issues `els_p` writes at addresses 0..els_p-1, one per cycle, with `mem_data_o = 0` and `mem_w_mask_o` all ones.
  - `ready_o = 0` throughout.
  - The FSM moves to `eRUN` after address els_p-1 is written; `ready_o` goes high in the next cycle.
  - Clear counter width is `addr_width_lp + 1`, so `els_p` that is a power of two does not wrap early.
- Undefined: no clear logic; `ready_o` goes high in the first cycle after reset.

## Structure
- Package `bsg_mem_1rw_rv_pkg` holds the state enum typedef (`eCLEAR`, `eRUN`).
- Response buffer is a `bsg_two_fifo` instance. The bypass mux and `inflight_r` live in this block.
- RAM is instantiated by the parent; this block only drives its port.

## Test plan
- Clear enabled, `els_p = 16`: reset for 2 cycles → 16 consecutive writes to addresses 0..15 with data 0 and mask `'1`, `ready_o` high in the 17th cycle after reset deasserts, then a read of address 5 returns 0.
- Write `0xA5` to address 3 with mask `0x0F` over prior data `0xFF` → next-cycle read returns `0xF5` with `v_o` at t+1.
- Reads of addresses 1, 2, 3 back-to-back with `yumi_i` held high → `v_o` high for three consecutive cycles, data in order, `ready_o` never drops.
- Reads of addresses 1 and 2 with `yumi_i = 0` → `ready_o = 0` from the following cycle. Asserting `yumi_i` for two cycles returns data for 1 then 2, and `ready_o` returns high after the first `yumi_i`.
- Reset asserted with one read in flight and one buffered → `v_o = 0` next cycle, no stale response after reset.
- Clear disabled: `ready_o = 1` in the first cycle after reset; a random mixed read/write stream matches the scoreboard over 10k cycles.
